// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the multi-issue instruction fetch queue.
// It holds the decode packet layout, the XLEN width and the NOP encoding used for empty slots.
package ifetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int FQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] PC;
  } IF_ID_PACKET;

  function automatic logic [XLEN-1:0] block_addr(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Bus bundle between the fetch queue, its redirect sources, the I-cache and decode.
// The slave modport is the fetch unit. The master modport is the surrounding pipeline.
interface ifetch_queue_if import ifetch_queue_pkg::*; #(
  parameter int FETCH_WIDTH = 2,
  parameter int FQ_DEPTH    = FQ_DEPTH_DEFAULT
);
  localparam int TW = $clog2(FETCH_WIDTH + 1);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic            certain_branch_req;
  logic [XLEN-1:0] certain_branch_pc;
  logic            rob_target_req;
  logic [XLEN-1:0] rob_target_pc;
  logic            branch_pred_req;
  logic [XLEN-1:0] branch_pred_pc;

  // Cache handshake: proc2Icache_req acts as ready and Icache2proc_data_valid acts as valid.
  // A block is accepted only in a cycle where both are high, and the address stays fixed until then.
  logic [63:0]     Icache2proc_data;
  logic            Icache2proc_data_valid;
  logic [XLEN-1:0] proc2Icache_addr;
  logic            proc2Icache_req;

  logic [TW-1:0]   id_take;
  IF_ID_PACKET     if_packet [FETCH_WIDTH];
  logic [CW-1:0]   fq_count;

  modport master (
    output certain_branch_req, certain_branch_pc,
    output rob_target_req, rob_target_pc,
    output branch_pred_req, branch_pred_pc,
    output Icache2proc_data, Icache2proc_data_valid,
    output id_take,
    input  proc2Icache_addr, proc2Icache_req,
    input  if_packet, fq_count
  );

  modport slave (
    input  certain_branch_req, certain_branch_pc,
    input  rob_target_req, rob_target_pc,
    input  branch_pred_req, branch_pred_pc,
    input  Icache2proc_data, Icache2proc_data_valid,
    input  id_take,
    output proc2Icache_addr, proc2Icache_req,
    output if_packet, fq_count
  );

endinterface

// File: rtl/ifetch_queue_fetch_queue.sv
// Circular instruction buffer with up to two enqueues and FETCH_WIDTH dequeues per cycle.
// The oldest entries are presented combinationally, and a flush empties the buffer.
module fetch_queue import ifetch_queue_pkg::*; #(
  parameter int FETCH_WIDTH = 2,
  parameter int FQ_DEPTH    = FQ_DEPTH_DEFAULT,
  localparam int PW = $clog2(FQ_DEPTH),
  localparam int CW = $clog2(FQ_DEPTH + 1),
  localparam int TW = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [1:0]                enq_cnt,
  input  logic [1:0][31:0]          enq_inst,
  input  logic [1:0][XLEN-1:0]      enq_pc,
  input  logic [TW-1:0]             deq_cnt,
  output IF_ID_PACKET               packets [FETCH_WIDTH],
  output logic [CW-1:0]             count
);

  logic [31:0]     inst_mem [FQ_DEPTH];
  logic [XLEN-1:0] pc_mem   [FQ_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   rd_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_cnt);
      tail  <= tail + PW'(enq_cnt);
      count <= count + CW'(enq_cnt) - CW'(deq_cnt);
    end
  end

  // The storage array needs no reset because validity comes from count alone.
  always_ff @(posedge clock) begin
    if (enq_cnt != 2'd0) begin
      inst_mem[tail] <= enq_inst[0];
      pc_mem[tail]   <= enq_pc[0];
    end
    if (enq_cnt == 2'd2) begin
      inst_mem[tail + PW'(1)] <= enq_inst[1];
      pc_mem[tail + PW'(1)]   <= enq_pc[1];
    end
  end

  always_comb begin
    rd_idx = head;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      packets[i] = '{valid: 1'b0, inst: NOP, NPC: '0, PC: '0};
      rd_idx = head + PW'(i);
      if (CW'(i) < count) begin
        packets[i].valid = 1'b1;
        packets[i].inst  = inst_mem[rd_idx];
        packets[i].PC    = pc_mem[rd_idx];
        packets[i].NPC   = pc_mem[rd_idx] + XLEN'(4);
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage top: redirect mux and I-cache request logic feeding the circular fetch queue.
// Resolved branches and ROB targets flush the queue, while predictions only steer the next block address.
module ifetch_queue import ifetch_queue_pkg::*; #(
  parameter int FETCH_WIDTH = 2,
  parameter int FQ_DEPTH    = FQ_DEPTH_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  ifetch_queue_if.slave bus
);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0]      fetch_pc;
  logic [XLEN-1:0]      seq_pc;
  logic                 flush;
  logic                 req;
  logic                 accept;
  logic [1:0]           enq_cnt;
  logic [1:0][31:0]     enq_inst;
  logic [1:0][XLEN-1:0] enq_pc;
  logic [CW-1:0]        count;

  assign flush  = bus.certain_branch_req || bus.rob_target_req;
  // Occupancy is sampled before this cycle's dequeue, so two free slots are always available.
  assign req    = !reset && !flush && (count <= CW'(FQ_DEPTH - 2));
  assign accept = req && bus.Icache2proc_data_valid;
  assign seq_pc = {fetch_pc[XLEN-1:3] + (XLEN-3)'(1), 3'b000};

  assign bus.proc2Icache_req  = req;
  assign bus.proc2Icache_addr = block_addr(fetch_pc);
  assign bus.fq_count         = count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= '0;
    end else if (bus.certain_branch_req) begin
      fetch_pc <= bus.certain_branch_pc;
    end else if (bus.rob_target_req) begin
      fetch_pc <= bus.rob_target_pc;
    end else if (accept) begin
      fetch_pc <= bus.branch_pred_req ? bus.branch_pred_pc : seq_pc;
    end
  end

  // An odd-word PC uses only the upper half of the block.
  always_comb begin
    enq_cnt  = 2'd0;
    enq_inst = '0;
    enq_pc   = '0;
    if (accept) begin
      enq_pc[0] = fetch_pc;
      if (!fetch_pc[2]) begin
        enq_cnt     = 2'd2;
        enq_inst[0] = bus.Icache2proc_data[31:0];
        enq_inst[1] = bus.Icache2proc_data[63:32];
        enq_pc[1]   = fetch_pc + XLEN'(4);
      end else begin
        enq_cnt     = 2'd1;
        enq_inst[0] = bus.Icache2proc_data[63:32];
      end
    end
  end

  fetch_queue #(
    .FETCH_WIDTH(FETCH_WIDTH),
    .FQ_DEPTH   (FQ_DEPTH)
  ) u_fetch_queue (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .enq_cnt (enq_cnt),
    .enq_inst(enq_inst),
    .enq_pc  (enq_pc),
    .deq_cnt (bus.id_take),
    .packets (bus.if_packet),
    .count   (count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus a randomized run.
// A queue-level reference model supplies the expected fetch PC, request and packets.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int FW    = 2;
  localparam int DEPTH = 8;
  localparam int TW    = $clog2(FW + 1);
  localparam int CW    = $clog2(DEPTH + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ifetch_queue_if #(.FETCH_WIDTH(FW), .FQ_DEPTH(DEPTH)) bus ();

  ifetch_queue #(.FETCH_WIDTH(FW), .FQ_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the next fetch PC plus the ordered queue contents, each stored as {pc, inst}.
  logic [XLEN-1:0] m_pc;
  logic [63:0]     exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.certain_branch_req     = 1'b0;
    bus.certain_branch_pc      = '0;
    bus.rob_target_req         = 1'b0;
    bus.rob_target_pc          = '0;
    bus.branch_pred_req        = 1'b0;
    bus.branch_pred_pc         = '0;
    bus.Icache2proc_data       = '0;
    bus.Icache2proc_data_valid = 1'b0;
    bus.id_take                = '0;
  endtask

  // Apply one clock edge to the model using the currently driven inputs, then advance the DUT.
  task automatic tick();
    bit          acc;
    logic [63:0] d;
    if (bus.certain_branch_req || bus.rob_target_req) begin
      exp_q.delete();
      m_pc = bus.certain_branch_req ? bus.certain_branch_pc : bus.rob_target_pc;
    end else begin
      acc = bus.Icache2proc_data_valid && ((DEPTH - exp_q.size()) >= 2);
      d   = bus.Icache2proc_data;
      for (int k = 0; k < int'(bus.id_take); k++) void'(exp_q.pop_front());
      if (acc) begin
        if (m_pc[2] == 1'b0) begin
          exp_q.push_back({m_pc, d[31:0]});
          exp_q.push_back({m_pc + 32'd4, d[63:32]});
        end else begin
          exp_q.push_back({m_pc, d[63:32]});
        end
        m_pc = bus.branch_pred_req ? bus.branch_pred_pc : ((m_pc & 32'hFFFF_FFF8) + 32'd8);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    m_pc  = '0;
    exp_q.delete();
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #3;
    n_checks++;
    if (bus.proc2Icache_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", bus.proc2Icache_req); else n_pass++;
    n_checks++;
    if (bus.fq_count !== '0) $display("FAIL reset_count got=%0d exp=0", bus.fq_count); else n_pass++;
    n_checks++;
    if (bus.proc2Icache_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", bus.proc2Icache_addr); else n_pass++;
    for (int i = 0; i < FW; i++) begin
      n_checks++;
      if (bus.if_packet[i].valid !== 1'b0 || bus.if_packet[i].inst !== NOP)
        $display("FAIL reset_pkt%0d got valid=%b inst=%h exp valid=0 inst=%h", i, bus.if_packet[i].valid, bus.if_packet[i].inst, NOP);
      else n_pass++;
    end
    do_reset();
    n_checks++;
    if (bus.proc2Icache_req !== 1'b1) $display("FAIL post_reset_req got=%b exp=1", bus.proc2Icache_req); else n_pass++;
  endtask

  task automatic test_redirect_priority();
    do_reset();
    bus.certain_branch_req     = 1'b1;
    bus.certain_branch_pc      = 32'h1111_1111;
    bus.rob_target_req         = 1'b1;
    bus.rob_target_pc          = 32'h2222_2222;
    bus.branch_pred_req        = 1'b1;
    bus.branch_pred_pc         = 32'h3333_3330;
    bus.Icache2proc_data_valid = 1'b1;
    bus.Icache2proc_data       = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    n_checks++;
    if (bus.proc2Icache_req !== 1'b0) $display("FAIL redir_cycle_req got=%b exp=0", bus.proc2Icache_req); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.proc2Icache_addr !== 32'h1111_1110) $display("FAIL redir_addr got=%h exp=11111110", bus.proc2Icache_addr); else n_pass++;
    n_checks++;
    if (bus.proc2Icache_req !== 1'b1) $display("FAIL redir_req got=%b exp=1", bus.proc2Icache_req); else n_pass++;
    n_checks++;
    if (bus.fq_count !== '0 || bus.if_packet[0].valid !== 1'b0) $display("FAIL redir_empty got count=%0d v0=%b exp count=0 v0=0", bus.fq_count, bus.if_packet[0].valid); else n_pass++;
  endtask

  task automatic test_block_pair();
    do_reset();
    bus.Icache2proc_data_valid = 1'b1;
    bus.Icache2proc_data       = 64'hBBBB_BBBB_AAAA_AAAA;
    #1;
    n_checks++;
    if (bus.proc2Icache_req !== 1'b1 || bus.proc2Icache_addr !== 32'h0) $display("FAIL pair_req got req=%b addr=%h exp req=1 addr=0", bus.proc2Icache_req, bus.proc2Icache_addr); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.if_packet[0].valid !== 1'b1 || bus.if_packet[0].inst !== 32'hAAAA_AAAA || bus.if_packet[0].PC !== 32'h0 || bus.if_packet[0].NPC !== 32'h4)
      $display("FAIL pair_pkt0 got v=%b inst=%h pc=%h npc=%h exp v=1 inst=aaaaaaaa pc=0 npc=4", bus.if_packet[0].valid, bus.if_packet[0].inst, bus.if_packet[0].PC, bus.if_packet[0].NPC);
    else n_pass++;
    n_checks++;
    if (bus.if_packet[1].valid !== 1'b1 || bus.if_packet[1].inst !== 32'hBBBB_BBBB || bus.if_packet[1].PC !== 32'h4 || bus.if_packet[1].NPC !== 32'h8)
      $display("FAIL pair_pkt1 got v=%b inst=%h pc=%h npc=%h exp v=1 inst=bbbbbbbb pc=4 npc=8", bus.if_packet[1].valid, bus.if_packet[1].inst, bus.if_packet[1].PC, bus.if_packet[1].NPC);
    else n_pass++;
    n_checks++;
    if (bus.proc2Icache_addr !== 32'h8 || bus.fq_count !== CW'(2)) $display("FAIL pair_next got addr=%h count=%0d exp addr=8 count=2", bus.proc2Icache_addr, bus.fq_count); else n_pass++;
  endtask

  task automatic test_odd_word();
    do_reset();
    bus.certain_branch_req = 1'b1;
    bus.certain_branch_pc  = 32'h0000_0104;
    tick();
    idle();
    bus.Icache2proc_data_valid = 1'b1;
    bus.Icache2proc_data       = 64'h1234_5678_9ABC_DEF0;
    #1;
    n_checks++;
    if (bus.proc2Icache_addr !== 32'h100) $display("FAIL odd_addr got=%h exp=100", bus.proc2Icache_addr); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.fq_count !== CW'(1)) $display("FAIL odd_count got=%0d exp=1", bus.fq_count); else n_pass++;
    n_checks++;
    if (bus.if_packet[0].valid !== 1'b1 || bus.if_packet[0].inst !== 32'h1234_5678 || bus.if_packet[0].PC !== 32'h104 || bus.if_packet[0].NPC !== 32'h108)
      $display("FAIL odd_pkt0 got v=%b inst=%h pc=%h npc=%h exp v=1 inst=12345678 pc=104 npc=108", bus.if_packet[0].valid, bus.if_packet[0].inst, bus.if_packet[0].PC, bus.if_packet[0].NPC);
    else n_pass++;
    n_checks++;
    if (bus.if_packet[1].valid !== 1'b0 || bus.if_packet[1].inst !== NOP) $display("FAIL odd_pkt1 got v=%b inst=%h exp v=0 inst=%h", bus.if_packet[1].valid, bus.if_packet[1].inst, NOP); else n_pass++;
    n_checks++;
    if (bus.proc2Icache_addr !== 32'h108) $display("FAIL odd_next got=%h exp=108", bus.proc2Icache_addr); else n_pass++;
  endtask

  task automatic test_fill_and_drain();
    logic [63:0] e;
    bit          ok;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.Icache2proc_data_valid = 1'b1;
      bus.Icache2proc_data       = {$urandom(), $urandom()};
      tick();
    end
    #1;
    n_checks++;
    if (bus.fq_count !== CW'(8)) $display("FAIL full_count got=%0d exp=8", bus.fq_count); else n_pass++;
    n_checks++;
    if (bus.proc2Icache_req !== 1'b0) $display("FAIL full_req got=%b exp=0", bus.proc2Icache_req); else n_pass++;
    for (int c = 0; c < 12; c++) begin
      bus.id_take                = TW'(2);
      bus.Icache2proc_data_valid = 1'b1;
      bus.Icache2proc_data       = {$urandom(), $urandom()};
      #1;
      n_checks++;
      if (bus.fq_count !== CW'(exp_q.size())) $display("FAIL drain_count cyc=%0d got=%0d exp=%0d", c, bus.fq_count, exp_q.size()); else n_pass++;
      for (int i = 0; i < FW; i++) begin
        e = exp_q[i];
        ok = bus.if_packet[i].valid === 1'b1 && bus.if_packet[i].inst === e[31:0] && bus.if_packet[i].PC === e[63:32];
        n_checks++;
        if (!ok) $display("FAIL drain_pkt%0d cyc=%0d got inst=%h pc=%h exp inst=%h pc=%h", i, c, bus.if_packet[i].inst, bus.if_packet[i].PC, e[31:0], e[63:32]);
        else n_pass++;
      end
      if (c == 1) begin
        n_checks++;
        if (bus.proc2Icache_req !== 1'b1) $display("FAIL drain_req_resume got=%b exp=1", bus.proc2Icache_req); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_rob_flush();
    idle();
    bus.rob_target_req         = 1'b1;
    bus.rob_target_pc          = 32'h0000_0200;
    bus.Icache2proc_data_valid = 1'b1;
    bus.Icache2proc_data       = 64'h5555_5555_6666_6666;
    bus.id_take                = TW'(2);
    #1;
    n_checks++;
    if (bus.proc2Icache_req !== 1'b0) $display("FAIL rob_cycle_req got=%b exp=0", bus.proc2Icache_req); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.fq_count !== '0) $display("FAIL rob_count got=%0d exp=0", bus.fq_count); else n_pass++;
    n_checks++;
    if (bus.if_packet[0].valid !== 1'b0 || bus.if_packet[1].valid !== 1'b0) $display("FAIL rob_pkts got v0=%b v1=%b exp v0=0 v1=0", bus.if_packet[0].valid, bus.if_packet[1].valid); else n_pass++;
    n_checks++;
    if (bus.proc2Icache_addr !== 32'h200 || bus.proc2Icache_req !== 1'b1) $display("FAIL rob_addr got addr=%h req=%b exp addr=200 req=1", bus.proc2Icache_addr, bus.proc2Icache_req); else n_pass++;
  endtask

  task automatic test_pred();
    do_reset();
    bus.certain_branch_req = 1'b1;
    bus.certain_branch_pc  = 32'h0000_0010;
    tick();
    idle();
    bus.Icache2proc_data_valid = 1'b1;
    bus.Icache2proc_data       = 64'h2222_2222_1111_1111;
    bus.branch_pred_req        = 1'b1;
    bus.branch_pred_pc         = 32'h0000_0400;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.fq_count !== CW'(2)) $display("FAIL pred_count got=%0d exp=2", bus.fq_count); else n_pass++;
    n_checks++;
    if (bus.if_packet[0].PC !== 32'h10 || bus.if_packet[0].inst !== 32'h1111_1111) $display("FAIL pred_pkt0 got pc=%h inst=%h exp pc=10 inst=11111111", bus.if_packet[0].PC, bus.if_packet[0].inst); else n_pass++;
    n_checks++;
    if (bus.if_packet[1].PC !== 32'h14 || bus.if_packet[1].inst !== 32'h2222_2222) $display("FAIL pred_pkt1 got pc=%h inst=%h exp pc=14 inst=22222222", bus.if_packet[1].PC, bus.if_packet[1].inst); else n_pass++;
    n_checks++;
    if (bus.proc2Icache_addr !== 32'h400) $display("FAIL pred_addr got=%h exp=400", bus.proc2Icache_addr); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] e;
    logic [XLEN-1:0] exp_pc;
    bit          ok;
    bit          exp_req;
    int          r;
    int          lim;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      idle();
      r = $urandom_range(0, 19);
      bus.certain_branch_req     = (r == 0);
      bus.certain_branch_pc      = $urandom() & 32'hFFFF_FFFC;
      bus.rob_target_req         = (r <= 1) && ($urandom_range(0, 1) == 1);
      bus.rob_target_pc          = $urandom() & 32'hFFFF_FFFC;
      bus.branch_pred_req        = ($urandom_range(0, 3) == 0);
      bus.branch_pred_pc         = $urandom() & 32'hFFFF_FFFC;
      bus.Icache2proc_data_valid = ($urandom_range(0, 9) < 6);
      bus.Icache2proc_data       = {$urandom(), $urandom()};
      lim = (exp_q.size() < FW) ? exp_q.size() : FW;
      bus.id_take = TW'($urandom_range(0, lim));
      #1;
      exp_req = !(bus.certain_branch_req || bus.rob_target_req) && ((DEPTH - exp_q.size()) >= 2);
      exp_pc  = m_pc & 32'hFFFF_FFF8;
      n_checks++;
      if (bus.proc2Icache_req !== exp_req || bus.proc2Icache_addr !== exp_pc)
        $display("FAIL rnd_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h", c, bus.proc2Icache_req, bus.proc2Icache_addr, exp_req, exp_pc);
      else n_pass++;
      n_checks++;
      if (bus.fq_count !== CW'(exp_q.size())) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, bus.fq_count, exp_q.size()); else n_pass++;
      for (int i = 0; i < FW; i++) begin
        if (i < exp_q.size()) begin
          e  = exp_q[i];
          ok = bus.if_packet[i].valid === 1'b1 && bus.if_packet[i].inst === e[31:0] &&
               bus.if_packet[i].PC === e[63:32] && bus.if_packet[i].NPC === (e[63:32] + 32'd4);
        end else begin
          e  = '0;
          ok = bus.if_packet[i].valid === 1'b0 && bus.if_packet[i].inst === NOP;
        end
        n_checks++;
        if (!ok) $display("FAIL rnd_pkt%0d cyc=%0d got v=%b inst=%h pc=%h npc=%h exp v=%0d inst=%h pc=%h", i, c, bus.if_packet[i].valid, bus.if_packet[i].inst, bus.if_packet[i].PC, bus.if_packet[i].NPC, (i < exp_q.size()), e[31:0], e[63:32]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bus.Icache2proc_data_valid = 1'b1;
      bus.Icache2proc_data       = {$urandom(), $urandom()};
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.fq_count !== '0 || bus.if_packet[0].valid !== 1'b0) $display("FAIL areset_queue got count=%0d v0=%b exp count=0 v0=0", bus.fq_count, bus.if_packet[0].valid); else n_pass++;
    n_checks++;
    if (bus.proc2Icache_addr !== 32'h0 || bus.proc2Icache_req !== 1'b0) $display("FAIL areset_req got addr=%h req=%b exp addr=0 req=0", bus.proc2Icache_addr, bus.proc2Icache_req); else n_pass++;
    do_reset();
  endtask

  initial begin
    idle();
    test_reset();
    test_redirect_priority();
    test_block_pair();
    test_odd_word();
    test_fill_and_drain();
    test_rob_flush();
    test_pred();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
